// File: rtl/uart_baud_pkg.sv
// uart_baud_pkg: BaudSel codes, preset baud table and the Q4 divisor function.
//   BAUD_* codes : BaudSel encodings (BAUD_CUSTOM selects CustomDiv)
//   BAUD_RATE    : baud rate for each preset code
//   FRAC_W       : fraction bits of the Q(DIV_W).4 divisor
//   q4Div()      : round(clkFreq*16 / (baud*overSample))
package uart_baud_pkg;
    typedef enum logic [2:0] {
        BAUD_2400, BAUD_4800, BAUD_9600, BAUD_19200,
        BAUD_38400, BAUD_57600, BAUD_115200, BAUD_CUSTOM
    } baudSel_e;
    localparam int FRAC_W = 4;
    localparam int unsigned BAUD_RATE [7] = '{2400, 4800, 9600, 19200, 38400, 57600, 115200};
    function automatic longint unsigned q4Div(input longint unsigned clkFreq,
                                              input longint unsigned overSample,
                                              input longint unsigned baud);
        longint unsigned d;
        d = baud * overSample;
        return (clkFreq * 64'd16 + d / 64'd2) / d;
    endfunction
endpackage

// File: rtl/baud_tick_gen_if.sv
// baud_tick_gen_if: control and tick bundle of the baud generator.
//   Enable, Resync, BaudSel, CustomDiv : controls driven by the user (master)
//   OsTick, MidTick, BitTick, Phase, DivErr : registered outputs of the generator (slave)
interface baud_tick_gen_if #(
    parameter int DIV_W      = 16,
    parameter int OVERSAMPLE = 16
);
    logic                          Enable;
    logic                          Resync;
    logic [2:0]                    BaudSel;
    logic [DIV_W+3:0]              CustomDiv;
    logic                          OsTick;
    logic                          MidTick;
    logic                          BitTick;
    logic [$clog2(OVERSAMPLE)-1:0] Phase;
    logic                          DivErr;
    modport master (output Enable, Resync, BaudSel, CustomDiv,
                    input  OsTick, MidTick, BitTick, Phase, DivErr);
    modport slave  (input  Enable, Resync, BaudSel, CustomDiv,
                    output OsTick, MidTick, BitTick, Phase, DivErr);
endinterface

// File: rtl/baud_frac_div.sv
// baud_frac_div: integer down-counter plus 4-bit fraction accumulator giving the raw OsTick.
//   Clock, ResetN    : clock, async active-low reset
//   enable, restart  : run enable; restart reloads divInt and clears the fraction
//   divInt, divFrac  : integer and fractional divisor parts
//   rawTick          : one-cycle tick due this cycle (registered by the top)
module baud_frac_div
    import uart_baud_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic              Clock,
    input  logic              ResetN,
    input  logic              enable,
    input  logic              restart,
    input  logic [DIV_W-1:0]  divInt,
    input  logic [FRAC_W-1:0] divFrac,
    output logic              rawTick
);
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] fracAcc;
    logic [FRAC_W:0]   fracSum;
    always_comb begin
        fracSum = {1'b0, fracAcc} + {1'b0, divFrac};
        rawTick = enable && !restart && cnt == DIV_W'(1);
    end
    // The fraction carry stretches the following period by one cycle.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            cnt     <= '0;
            fracAcc <= '0;
        end else if (restart) begin
            cnt     <= divInt;
            fracAcc <= '0;
        end else if (rawTick) begin
            cnt     <= divInt + DIV_W'(fracSum[FRAC_W]);
            fracAcc <= fracSum[FRAC_W-1:0];
        end else if (enable) begin
            cnt     <= cnt - DIV_W'(1);
        end
    end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: UART baud generator with oversample, mid-bit and bit ticks.
//   Clock, ResetN : clock, async active-low reset
//   bus (slave)   : Enable/Resync/BaudSel/CustomDiv in; OsTick/MidTick/BitTick/Phase/DivErr out
module baud_tick_gen
    import uart_baud_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input logic            Clock,
    input logic            ResetN,
    baud_tick_gen_if.slave bus
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    logic [DIV_W+3:0] q4Tab [8];
    logic [DIV_W+3:0] prevDiv;
    logic [2:0]       prevSel;
    logic [DIV_W-1:0] divInt;
    logic [FRAC_W-1:0] divFrac;
    logic [PH_W-1:0]  phNext;
    logic             started, errNow, restart, rawTick;
    for (genvar g = 0; g < 7; g++) begin : gPreset
        assign q4Tab[g] = (DIV_W+FRAC_W)'(q4Div(64'(CLK_FREQ), 64'(OVERSAMPLE), 64'(BAUD_RATE[g])));
    end
    assign q4Tab[7] = bus.CustomDiv;
    // A registered DivErr forces one more restart on the cycle the error clears.
    always_comb begin
        {divInt, divFrac} = q4Tab[bus.BaudSel];
        errNow  = divInt < DIV_W'(2);
        restart = bus.Enable && (bus.Resync || !started || bus.BaudSel != prevSel ||
                                 bus.CustomDiv != prevDiv || errNow || bus.DivErr);
        phNext  = bus.Phase + PH_W'(1);
    end
    baud_frac_div #(.DIV_W(DIV_W)) uDiv (
        .Clock   (Clock),
        .ResetN  (ResetN),
        .enable  (bus.Enable),
        .restart (restart),
        .divInt  (divInt),
        .divFrac (divFrac),
        .rawTick (rawTick)
    );
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            started     <= 1'b0;
            prevSel     <= '0;
            prevDiv     <= '0;
            bus.DivErr  <= 1'b0;
            bus.OsTick  <= 1'b0;
            bus.MidTick <= 1'b0;
            bus.BitTick <= 1'b0;
            bus.Phase   <= '0;
        end else if (bus.Enable) begin
            started     <= 1'b1;
            prevSel     <= bus.BaudSel;
            prevDiv     <= bus.CustomDiv;
            bus.DivErr  <= errNow;
            bus.OsTick  <= rawTick;
            bus.MidTick <= rawTick && phNext == PH_W'(OVERSAMPLE / 2);
            bus.BitTick <= rawTick && phNext == '0;
            bus.Phase   <= restart ? '0 : rawTick ? phNext : bus.Phase;
        end else begin
            bus.OsTick  <= 1'b0;
            bus.MidTick <= 1'b0;
            bus.BitTick <= 1'b0;
        end
    end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed self-checking bench for baud_tick_gen at 50 MHz, 16x oversample.
module tb_baud_tick_gen;
    logic Clock = 1'b0;
    logic ResetN;
    int   cyc = 0;
    int   nChecks = 0;
    int   nFail = 0;
    baud_tick_gen_if #(.DIV_W(16), .OVERSAMPLE(16)) bus ();
    baud_tick_gen #(.CLK_FREQ(50_000_000), .OVERSAMPLE(16), .DIV_W(16)) dut (
        .Clock  (Clock),
        .ResetN (ResetN),
        .bus    (bus)
    );
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    function automatic bit sigOn(input int sel);
        return sel == 0 ? bus.OsTick : sel == 1 ? bus.MidTick : bus.BitTick;
    endfunction
    // Advances at least one negedge, then waits for the selected tick; at = cycle count seen.
    task automatic waitTick(input string tag, input int sel, input int limit, output int at);
        int n = 0;
        @(negedge Clock);
        while (!sigOn(sel) && n < limit) begin
            @(negedge Clock);
            n++;
        end
        if (!sigOn(sel)) check({tag, "_timeout"}, 0, 1);
        at = cyc;
    endtask
    initial begin
        int at, prev, iv, sum, bad, c0, b1, b2, m, d, t, p;
        ResetN = 1'b0;
        bus.Enable = 1'b0;
        bus.Resync = 1'b0;
        bus.BaudSel = 3'd2;
        bus.CustomDiv = '0;
        repeat (3) @(negedge Clock);
        check("rst_ostick", bus.OsTick, 0);
        check("rst_midtick", bus.MidTick, 0);
        check("rst_bittick", bus.BitTick, 0);
        check("rst_phase", bus.Phase, 0);
        check("rst_diverr", bus.DivErr, 0);
        bus.Enable = 1'b1;
        @(negedge Clock);
        ResetN = 1'b1;
        c0 = cyc;
        waitTick("first9600", 0, 400, at);
        check("first_os_9600", at - c0, 1 + 325);
        prev = at; sum = 0; bad = 0;
        for (int i = 0; i < 16; i++) begin
            waitTick("iv9600", 0, 400, at);
            iv = at - prev;
            sum += iv;
            if (iv != 325 && iv != 326) bad++;
            prev = at;
        end
        check("span16_9600", sum, 5208);
        check("iv_range_9600", bad, 0);
        waitTick("bit9600a", 2, 6000, b1);
        check("bit_phase0", bus.Phase, 0);
        check("bit_with_os", bus.OsTick, 1);
        waitTick("bit9600b", 2, 6000, b2);
        check("bit_gap_9600", b2 - b1, 5208);
        waitTick("mid9600", 1, 6000, m);
        check("mid_phase8", bus.Phase, 8);
        check("mid_with_os", bus.OsTick, 1);
        waitTick("pre_ph5", 0, 400, prev);
        iv = 0;
        for (int i = 0; i < 20 && bus.Phase != 5; i++) begin
            waitTick("seek_ph5", 0, 400, at);
            iv = at - prev;
            prev = at;
        end
        check("found_ph5", bus.Phase, 5);
        p = iv == 325 ? 326 : 325;
        repeat (p - 1) @(negedge Clock);
        bus.Resync = 1'b1;
        c0 = cyc;
        @(negedge Clock);
        bus.Resync = 1'b0;
        check("resync_drop", bus.OsTick, 0);
        check("resync_phase", bus.Phase, 0);
        waitTick("resync_os", 0, 400, at);
        check("resync_gap", at - c0, 1 + 325);
        check("resync_ph1", bus.Phase, 1);
        bus.BaudSel = 3'd6;
        c0 = cyc;
        waitTick("first115k", 0, 100, at);
        check("first_os_115k", at - c0, 1 + 27);
        waitTick("bit115a", 2, 1000, b1);
        waitTick("mid115", 1, 1000, m);
        d = m - b1;
        check("mid_gap_115k", d >= 216 && d <= 218, 1);
        waitTick("bit115b", 2, 1000, b2);
        check("bit_gap_115k", b2 - b1, 434);
        waitTick("bit_freeze", 2, 1000, t);
        repeat (10) @(negedge Clock);
        bus.Enable = 1'b0;
        bad = 0; iv = 0;
        repeat (100) begin
            @(negedge Clock);
            if (bus.OsTick || bus.MidTick || bus.BitTick) bad++;
            if (bus.Phase != 0) iv++;
        end
        check("freeze_ticks", bad, 0);
        check("freeze_phase", iv, 0);
        bus.Enable = 1'b1;
        waitTick("resume", 0, 200, at);
        check("resume_gap", at - t, 128);
        bus.BaudSel = 3'd7;
        bus.CustomDiv = 20'h0001_0;
        @(negedge Clock);
        check("diverr_set", bus.DivErr, 1);
        bad = 0;
        repeat (50) begin
            @(negedge Clock);
            if (bus.OsTick || bus.MidTick || bus.BitTick) bad++;
        end
        check("err_no_ticks", bad, 0);
        check("err_phase", bus.Phase, 0);
        bus.CustomDiv = 20'h0004_0;
        c0 = cyc;
        waitTick("custom_first", 0, 50, at);
        check("custom_first", at - c0, 1 + 4);
        check("diverr_clr", bus.DivErr, 0);
        prev = at;
        waitTick("custom_iv", 0, 50, at);
        check("custom_iv", at - prev, 4);
        bus.BaudSel = 3'd6;
        waitTick("rst_seek", 0, 100, at);
        for (int i = 0; i < 40 && bus.Phase != 5; i++) waitTick("rst_seek", 0, 100, at);
        check("rst_found_ph5", bus.Phase, 5);
        #1 ResetN = 1'b0;
        #1 check("async_clr", {bus.OsTick, bus.MidTick, bus.BitTick, bus.DivErr, bus.Phase}, 0);
        bad = 0;
        repeat (20) begin
            @(negedge Clock);
            if (bus.OsTick || bus.MidTick || bus.BitTick || bus.Phase != 0) bad++;
        end
        check("rst_held_quiet", bad, 0);
        ResetN = 1'b1;
        c0 = cyc;
        waitTick("post_rst", 0, 100, at);
        check("post_rst_first", at - c0, 1 + 27);
        check("post_rst_ph1", bus.Phase, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter CLK_FREQ, 50_000_000, input clock frequency in Hz.
REQ-002 Parameter OVERSAMPLE, 16, oversample ticks per bit; power of two, 4..32.
REQ-003 Parameter DIV_W, 16, integer width of the divisor.
REQ-004 Clock  in  1  single clock; all state updates on the rising edge.
REQ-005 ResetN  in  1  asynchronous, active-low reset.
REQ-006 Enable  in  1  high = run; low = hold all state, ticks forced 0.
REQ-007 Resync  in  1  synchronous restart of the divisor and phase (Rx start-bit edge).
REQ-008 BaudSel  in  3  0:2400, 1:4800, 2:9600, 3:19200, 4:38400, 5:57600, 6:115200, 7:custom.
REQ-009 CustomDiv  in  DIV_W+4  custom divisor, unsigned Q(DIV_W).4 clock cycles per OsTick.
REQ-010 OsTick  out  1  one-cycle pulse at the oversample rate.
REQ-011 MidTick  out  1  one-cycle pulse at mid-bit (Rx sample point).
REQ-012 BitTick  out  1  one-cycle pulse at bit rate (Tx shift point).
REQ-013 Phase  out  $clog2(OVERSAMPLE)  current oversample index within the bit.
REQ-014 DivErr  out  1  high when the selected divisor integer part is < 2.

Function
REQ-015 Preset divisor Q4 = round(CLK_FREQ*16/(baud*OVERSAMPLE)), computed at elaboration; Int = Q4[DIV_W+3:4], Frac = Q4[3:0].
REQ-016 A 4-bit fraction accumulator adds Frac at each OsTick; the carry-out lengthens the next OsTick period by one cycle.
REQ-017 OsTick period = Int or Int+1 cycles; every 16 consecutive OsTicks span exactly 16*Int+Frac cycles.
REQ-018 Restart condition = Resync OR a BaudSel/CustomDiv change from the previously registered value OR the first enabled cycle after reset.
REQ-019 Restart: counter reloads Int, FracAcc=0, Phase=0, no tick in that cycle; first OsTick asserts exactly Int cycles after the restart edge.
REQ-020 Resync takes priority over a tick due in the same cycle; the tick is dropped.
REQ-021 Phase increments on each OsTick and wraps from OVERSAMPLE-1 to 0.
REQ-022 BitTick asserts coincident with the OsTick that wraps Phase to 0.
REQ-023 MidTick asserts coincident with the OsTick that sets Phase to OVERSAMPLE/2.
REQ-024 Enable low: counter, FracAcc and Phase frozen; on re-enable, counting resumes with no restart.
REQ-025 Int < 2: DivErr=1, all ticks suppressed, state held in restart; leaving the error triggers a restart.
REQ-026 All outputs registered; no combinational path from inputs to outputs.

Reset
REQ-027 ResetN low asynchronously clears OsTick, MidTick, BitTick, DivErr=0, Phase=0, counter=0, FracAcc=0, started flag=0.
REQ-028 ResetN assertion mid-bit aborts the bit with no further tick; release is synchronous to Clock in effect (state changes only on the next edge).

Structure
REQ-029 Package uart_baud_pkg holds the BaudSel code constants, the baud-rate table, FRAC_W=4, and the Q4 divisor elaboration function.
REQ-030 One sub-module, baud_frac_div: integer counter plus fraction accumulator producing the raw OsTick; phase, mid and bit decode stay in baud_tick_gen.

Verification
REQ-031 50 MHz, BaudSel=2, Resync pulse: OsTick intervals 325/326 cycles; 16 OsTicks = 5208 cycles; BitTick every 5208 cycles.
REQ-032 BaudSel=6: Int=27, Frac=2; BitTick spacing 434 cycles; MidTick 217 +/-1 cycles after each BitTick.
REQ-033 Resync mid-bit (Phase=5): Phase returns to 0, the due tick is dropped, next OsTick exactly Int cycles later.
REQ-034 BaudSel=7, CustomDiv=0x0001_0 (Int=1): DivErr=1, no ticks; CustomDiv=0x0004_0: DivErr=0, OsTick every 4 cycles after restart.
REQ-035 Enable low for 100 cycles mid-count: ticks 0 and Phase frozen; resumes with the remaining count intact.
REQ-036 ResetN pulsed low mid-bit: all outputs 0 immediately; after release, first OsTick Int cycles after the first enabled edge.
